// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and the pure datapath helpers used by the LSU.
// byte_merge builds a store word; load_extend pulls a sub-word out of a loaded word.
package lsu_pkg;

    typedef enum logic [2:0] {IDLE, READ, WRITE, LOAD, FAULT, RESP} lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Little-endian: byte k of the word lives in bits [8k+7:8k].
    function automatic logic [31:0] byte_merge(input logic [31:0] word,
                                               input logic [31:0] wdata,
                                               input logic [2:0]  funct3,
                                               input logic [1:0]  off);
        logic [31:0] r;
        r = word;
        case (funct3)
            F3_B: begin
                case (off)
                    2'd0:    r[7:0]   = wdata[7:0];
                    2'd1:    r[15:8]  = wdata[7:0];
                    2'd2:    r[23:16] = wdata[7:0];
                    default: r[31:24] = wdata[7:0];
                endcase
            end
            F3_H: begin
                if (off[1]) r[31:16] = wdata[15:0];
                else        r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  funct3,
                                                input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_BU:   r = {24'h0, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_HU:   r = {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response and data-memory signals of the LSU in one bundle.
// The master side is the core plus memory; the slave side is the LSU itself.
interface lsu_if #(parameter int ADDR_W = 32);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_fault;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              mem_we;
    logic [31:0]       mem_wdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational LSU datapath: fault decode for the incoming request, plus
// load extension and store merge for the latched access.
module lsu_align
    import lsu_pkg::*;
#(
    parameter bit FAULT_MISALIGN = 1'b1
) (
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [1:0]  req_off_i,
    output logic        req_fault_o,
    output logic [1:0]  req_off_o,
    input  logic [2:0]  lat_funct3_i,
    input  logic [1:0]  lat_off_i,
    input  logic [31:0] mem_rdata_i,
    input  logic [31:0] lat_wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o
);

    logic illegal;
    logic misaligned;
    logic is_half;

    // Without misalignment faults the offending low address bits are simply cleared.
    always_comb begin
        is_half    = (req_funct3_i == F3_H) || (req_funct3_i == F3_HU);
        illegal    = req_we_i ? !(req_funct3_i inside {F3_B, F3_H, F3_W})
                              :  (req_funct3_i inside {3'b011, 3'b110, 3'b111});
        misaligned = (is_half && req_off_i[0]) ||
                     ((req_funct3_i == F3_W) && (req_off_i != 2'b00));
        req_fault_o = illegal || (FAULT_MISALIGN && misaligned);
        req_off_o   = req_off_i;
        if (!FAULT_MISALIGN) begin
            if (is_half)                         req_off_o = {req_off_i[1], 1'b0};
            else if (req_funct3_i == F3_W)       req_off_o = 2'b00;
        end
    end

    assign load_data_o  = load_extend(mem_rdata_i, lat_funct3_i, lat_off_i);
    assign merge_data_o = byte_merge(mem_rdata_i, lat_wdata_i, lat_funct3_i, lat_off_i);

endmodule

// File: rtl/lsu_subword.sv
// Load/store unit adding byte/halfword access on top of a word-only data memory.
// Sub-word stores go through a READ then WRITE read-modify-write pass.
module lsu_subword
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter bit FAULT_MISALIGN = 1'b1
) (
    input  logic  clk,
    input  logic  reset,
    lsu_if.slave  bus
);

    lsu_state_t        state_q, state_d;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              fault_q;
    logic [31:0]       mem_wdata_q;

    logic        accept;
    logic        req_fault;
    logic [1:0]  req_off;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    lsu_align #(.FAULT_MISALIGN(FAULT_MISALIGN)) u_align (
        .req_we_i     (bus.req_we),
        .req_funct3_i (bus.req_funct3),
        .req_off_i    (bus.req_addr[1:0]),
        .req_fault_o  (req_fault),
        .req_off_o    (req_off),
        .lat_funct3_i (funct3_q),
        .lat_off_i    (addr_q[1:0]),
        .mem_rdata_i  (bus.mem_rdata),
        .lat_wdata_i  (wdata_q),
        .load_data_o  (load_data),
        .merge_data_o (merge_data)
    );

    assign accept = bus.req_valid && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_fault)                   state_d = FAULT;
                    else if (!bus.req_we)            state_d = LOAD;
                    else if (bus.req_funct3 == F3_W) state_d = WRITE;
                    else                             state_d = READ;
                end
            end
            READ:    state_d = WRITE;
            WRITE:   state_d = RESP;
            LOAD:    state_d = RESP;
            FAULT:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A full-word store skips READ, so its write word is captured straight from the request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            funct3_q    <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            rdata_q     <= 32'h0;
            fault_q     <= 1'b0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                funct3_q <= bus.req_funct3;
                addr_q   <= {bus.req_addr[ADDR_W-1:2], req_off};
                wdata_q  <= bus.req_wdata;
                rdata_q  <= 32'h0;
                fault_q  <= 1'b0;
                if (state_d == WRITE) mem_wdata_q <= bus.req_wdata;
            end
            case (state_q)
                READ:    mem_wdata_q <= merge_data;
                LOAD:    rdata_q     <= load_data;
                FAULT:   fault_q     <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_fault = fault_q;
    assign bus.mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_we     = (state_q == WRITE) && !reset;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_subword.sv
// Directed bench for lsu_subword against a small word-addressed memory model.
// Expected values are hand-computed constants.
module tb_lsu_subword;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lsu_if #(.ADDR_W(32)) bus();

    lsu_subword #(.ADDR_W(32), .FAULT_MISALIGN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [0:63];
    logic        pokeEn  = 1'b0;
    logic [5:0]  pokeIdx = 6'd0;
    logic [31:0] pokeVal = 32'h0;
    int          writeCount = 0;
    int          checks = 0;
    int          errors = 0;

    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    // Memory model: LSU writes take priority over bench pokes.
    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
            writeCount <= writeCount + 1;
        end else if (pokeEn) begin
            mem[pokeIdx] <= pokeVal;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic pokeWord(input logic [5:0] idx, input logic [31:0] val);
        @(negedge clk);
        pokeEn  = 1'b1;
        pokeIdx = idx;
        pokeVal = val;
        @(negedge clk);
        pokeEn  = 1'b0;
    endtask

    // Issues one request and returns at the negedge on which resp_valid is seen.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rdata,
                                 output logic fault, output int lat);
        int guard;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (bus.resp_valid) break;
        end
        if (!bus.resp_valid) lat = 99;
        rdata = bus.resp_rdata;
        fault = bus.resp_fault;
    endtask

    logic [31:0] rd;
    logic        flt;
    int          lat;
    int          wcBefore;
    logic        weQ [3];
    logic [2:0]  f3Q [3];
    logic [31:0] adQ [3];
    logic [31:0] wdQ [3];
    int          acc [3];
    logic [31:0] rsp [3];
    int          nAcc, nRsp, cyc, readyCycles;
    logic        acceptNow;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;

        for (int i = 0; i < 64; i++) pokeWord(i[5:0], 32'h0);
        @(negedge clk);
        checkOutput("rst_ready",     {31'h0, bus.req_ready},  32'd1);
        checkOutput("rst_respvalid", {31'h0, bus.resp_valid}, 32'd0);
        checkOutput("rst_rdata",     bus.resp_rdata,          32'h0);
        checkOutput("rst_fault",     {31'h0, bus.resp_fault}, 32'd0);
        checkOutput("rst_memwe",     {31'h0, bus.mem_we},     32'd0);
        checkOutput("rst_memaddr",   bus.mem_addr,            32'h0);
        checkOutput("rst_memwdata",  bus.mem_wdata,           32'h0);
        reset = 1'b0;

        $display("[TB] sign/zero-extended byte loads");
        pokeWord(6'd4, 32'h8899AABB);
        applyStimulus(1'b0, F3_B, 32'h11, 32'h0, rd, flt, lat);
        checkOutput("lb_data", rd, 32'hFFFFFFAA);
        checkOutput("lb_lat",  lat, 32'd2);
        applyStimulus(1'b0, F3_BU, 32'h11, 32'h0, rd, flt, lat);
        checkOutput("lbu_data", rd, 32'h000000AA);
        checkOutput("lbu_lat",  lat, 32'd2);

        $display("[TB] byte store read-modify-write");
        pokeWord(6'd4, 32'h11223344);
        wcBefore = writeCount;
        applyStimulus(1'b1, F3_B, 32'h12, 32'h000000EE, rd, flt, lat);
        checkOutput("sb_lat",    lat, 32'd3);
        checkOutput("sb_rdata",  rd, 32'h0);
        checkOutput("sb_fault",  {31'h0, flt}, 32'd0);
        checkOutput("sb_writes", writeCount - wcBefore, 32'd1);
        checkOutput("sb_mem",    mem[4], 32'h11EE3344);
        applyStimulus(1'b0, F3_W, 32'h10, 32'h0, rd, flt, lat);
        checkOutput("lw_after_sb", rd, 32'h11EE3344);

        $display("[TB] faults");
        wcBefore = writeCount;
        applyStimulus(1'b1, F3_H, 32'h13, 32'h0000BEEF, rd, flt, lat);
        checkOutput("sh_mis_fault", {31'h0, flt}, 32'd1);
        checkOutput("sh_mis_lat",   lat, 32'd2);
        checkOutput("sh_mis_mem",   mem[4], 32'h11EE3344);
        applyStimulus(1'b0, F3_W, 32'h0E, 32'h0, rd, flt, lat);
        checkOutput("lw_mis_fault", {31'h0, flt}, 32'd1);
        checkOutput("lw_mis_rdata", rd, 32'h0);
        applyStimulus(1'b1, 3'b011, 32'h10, 32'h12345678, rd, flt, lat);
        checkOutput("st_ill_fault", {31'h0, flt}, 32'd1);
        checkOutput("fault_writes", writeCount - wcBefore, 32'd0);
        checkOutput("st_ill_mem",   mem[4], 32'h11EE3344);

        $display("[TB] halfword store and loads");
        applyStimulus(1'b1, F3_H, 32'h22, 32'h0000CAFE, rd, flt, lat);
        checkOutput("sh_mem", mem[8], 32'hCAFE0000);
        applyStimulus(1'b0, F3_H, 32'h22, 32'h0, rd, flt, lat);
        checkOutput("lh_data", rd, 32'hFFFFCAFE);
        applyStimulus(1'b0, F3_HU, 32'h22, 32'h0, rd, flt, lat);
        checkOutput("lhu_data", rd, 32'h0000CAFE);

        $display("[TB] back-to-back requests with req_valid held");
        weQ[0] = 1'b1; f3Q[0] = F3_W; adQ[0] = 32'h30; wdQ[0] = 32'h12345678;
        weQ[1] = 1'b1; f3Q[1] = F3_B; adQ[1] = 32'h31; wdQ[1] = 32'h000000AB;
        weQ[2] = 1'b0; f3Q[2] = F3_W; adQ[2] = 32'h30; wdQ[2] = 32'h0;
        wcBefore = writeCount;
        nAcc = 0; nRsp = 0; cyc = 0; readyCycles = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = weQ[0]; bus.req_funct3 = f3Q[0];
        bus.req_addr = adQ[0]; bus.req_wdata = wdQ[0];
        while (cyc < 30 && nRsp < 3) begin
            if (bus.resp_valid) begin
                rsp[nRsp] = bus.resp_rdata;
                nRsp++;
            end
            if (bus.req_ready) readyCycles++;
            acceptNow = bus.req_valid && bus.req_ready;
            if (acceptNow && nAcc < 3) begin
                acc[nAcc] = cyc;
                nAcc++;
            end
            @(posedge clk);
            #1;
            if (acceptNow) begin
                if (nAcc < 3) begin
                    bus.req_we = weQ[nAcc]; bus.req_funct3 = f3Q[nAcc];
                    bus.req_addr = adQ[nAcc]; bus.req_wdata = wdQ[nAcc];
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        checkOutput("b2b_accepts",   nAcc, 32'd3);
        checkOutput("b2b_responses", nRsp, 32'd3);
        checkOutput("b2b_ready_cyc", readyCycles, 32'd3);
        checkOutput("b2b_gap_sw",    acc[1] - acc[0], 32'd3);
        checkOutput("b2b_gap_sb",    acc[2] - acc[1], 32'd4);
        checkOutput("b2b_rsp0",      rsp[0], 32'h0);
        checkOutput("b2b_rsp2",      rsp[2], 32'h1234AB78);
        checkOutput("b2b_writes",    writeCount - wcBefore, 32'd2);
        checkOutput("b2b_mem",       mem[12], 32'h1234AB78);

        $display("[TB] reset during READ and WRITE");
        pokeWord(6'd16, 32'hA5A5A5A5);
        wcBefore = writeCount;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_B;
        bus.req_addr = 32'h40; bus.req_wdata = 32'h00000011;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rr_ready",     {31'h0, bus.req_ready},  32'd1);
        checkOutput("rr_respvalid", {31'h0, bus.resp_valid}, 32'd0);
        checkOutput("rr_memwe",     {31'h0, bus.mem_we},     32'd0);
        checkOutput("rr_memaddr",   bus.mem_addr,            32'h0);
        checkOutput("rr_memwdata",  bus.mem_wdata,           32'h0);
        reset = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_W;
        bus.req_addr = 32'h40; bus.req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1 checkOutput("rw_memwe_gated", {31'h0, bus.mem_we}, 32'd0);
        @(negedge clk);
        checkOutput("rw_ready",  {31'h0, bus.req_ready}, 32'd1);
        checkOutput("rw_memwdata", bus.mem_wdata, 32'h0);
        reset = 1'b0;
        checkOutput("rst_writes", writeCount - wcBefore, 32'd0);
        checkOutput("rst_mem",    mem[16], 32'hA5A5A5A5);
        applyStimulus(1'b0, F3_W, 32'h40, 32'h0, rd, flt, lat);
        checkOutput("post_rst_lw",  rd, 32'hA5A5A5A5);
        checkOutput("post_rst_lat", lat, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
